// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-op sequencer: downstream op codes,
// FSM state encoding and the queued command layout.
package reg_op_sequencer_pkg;

  localparam int CMD_DATA_W = 4;
  localparam int CMD_REP_W  = 3;

  // Downstream register-stage op encoding
  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_SHR  = 2'd2;
  localparam logic [1:0] OP_ROL  = 2'd3;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_ISSUE = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // One queued command at the default widths
  typedef struct packed {
    logic [1:0]            op;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_REP_W-1:0]  rep;
  } cmd_t;

endpackage

// File: rtl/reg_op_sequencer_fifo.sv
// Synchronous command FIFO with occupancy count and a flush that wins over
// any same-cycle push or pop. DEPTH must be a power of two so the pointers
// wrap naturally.
module reg_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == FULL_LVL);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array; written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= wdata;
  end

  // Pointers and occupancy; flush empties the queue outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Command sequencer feeding the 4-bit shift/rotate register stage.
// Commands are queued, then on start each one is popped (LOAD, one hold
// bubble) and issued for rep+1 cycles (ISSUE); DONE pulses once at the end.
// All downstream outputs decode from registered state only.
// Optional: define REG_OP_SEQ_SHADOW_EN to add the shadow output, a local
// model of the downstream register value.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REP_W  = 3,
  parameter int DATA_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic [REP_W-1:0]       cmd_rep,
  input  logic                   start,
  input  logic                   abort,
  output logic [1:0]             op_reg,
  output logic [DATA_W-1:0]      sel_r,
  output logic                   busy,
  output logic                   done,
`ifdef REG_OP_SEQ_SHADOW_EN
  output logic [DATA_W-1:0]      shadow,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam int W = 2 + DATA_W + REP_W;

  state_t            state_q, state_d;
  logic [1:0]        cur_op_q;
  logic [DATA_W-1:0] cur_data_q;
  logic [REP_W-1:0]  cnt_q;

  logic              full, empty, push, pop;
  logic [W-1:0]      head;

  // A push during abort is dropped along with the rest of the queue
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready && !abort;
  assign pop       = (state_q == S_LOAD);

  reg_op_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata ({cmd_op, cmd_data, cmd_rep}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Next-state: LOAD only with work queued; an issue-time push keeps the
  // program running. abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = empty ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: if (cnt_q == '0) state_d = (!empty || push) ? S_LOAD : S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State register and the command currently being issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_op_q   <= OP_HOLD;
      cur_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_LOAD) begin
        {cur_op_q, cur_data_q, cnt_q} <= head;
      end else if (state_q == S_ISSUE && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign op_reg = (state_q == S_ISSUE) ? cur_op_q : OP_HOLD;
  assign sel_r  = (state_q == S_ISSUE) ? cur_data_q : '0;
  assign busy   = (state_q == S_LOAD) || (state_q == S_ISSUE);
  assign done   = (state_q == S_DONE);

`ifdef REG_OP_SEQ_SHADOW_EN
  logic [DATA_W-1:0] shadow_q;

  // Mirror of the downstream register, stepping on the same edge it does
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      case (op_reg)
        OP_LOAD: shadow_q <= sel_r;
        OP_SHR:  shadow_q <= {1'b0, shadow_q[DATA_W-1:1]};
        OP_ROL:  shadow_q <= {shadow_q[DATA_W-2:0], shadow_q[DATA_W-1]};
        default: shadow_q <= shadow_q;
      endcase
    end
  end

  assign shadow = shadow_q;
`endif

endmodule
